// File: rtl/ysyx_22040237_ctrl_pkg.sv
// Purpose : shared state encoding and halt codes for the multi-cycle core sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package ysyx_22040237_ctrl_pkg;

    // Sequencer states; the encoding is visible on state_o for debug.
    typedef enum logic [3:0] {
        RESET    = 4'd0,
        IF_REQ   = 4'd1,
        IF_WAIT  = 4'd2,
        ID       = 4'd3,
        EX       = 4'd4,
        MEM_REQ  = 4'd5,
        MEM_WAIT = 4'd6,
        WB       = 4'd7,
        HALT     = 4'd8
    } ctrl_state_e;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_EBREAK  = 2'b01;
    localparam logic [1:0] HALT_INVALID = 2'b10;
    localparam logic [1:0] HALT_BUSERR  = 2'b11;

    // States in which the shared wait timer is running.
    function automatic logic is_wait_state(input ctrl_state_e s);
        return (s == IF_WAIT) || (s == MEM_WAIT);
    endfunction

endpackage

// File: rtl/ysyx_22040237_wait_timer.sv
// Purpose : response-wait watchdog shared by the fetch and memory wait states.
// Latency : expire is combinational from the count; count updates one cycle after enable.
// Backpr. : none; the count saturates at WAIT_MAX-1 until cleared.
// Ports   : clk, rst (async, active-high), clear (zero the count), enable (count this cycle),
//           expire (count has reached WAIT_MAX-1).
module ysyx_22040237_wait_timer #(
    parameter int WAIT_MAX = 16,   // must be >= 2
    parameter int WAIT_W   = 5     // 2**WAIT_W must exceed WAIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Purpose : multi-cycle core sequencer: fetch, decode wait, execute, load/store, writeback, halt.
// Latency : ALU/branch 5 cycles with zero-wait memory, load/store 7 cycles minimum.
// Backpr. : request valids held until ready; at most one outstanding request; WAIT_MAX-cycle timeout.
// Ports   : IFU req/rsp handshake, instruction latch enable, decoder class flags, LSU req/rsp
//           handshake, EXU capture, regfile write / PC update strobes, sticky halt + code, debug state.
// Option  : YSYX_22040237_PERF_CNT_EN adds cycle_cnt_o / instret_o performance counters.
module ysyx_22040237_mcyc_ctrl
    import ysyx_22040237_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int WAIT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic       ifu_req_valid_o,
    input  logic       ifu_req_ready_i,
    input  logic       ifu_rsp_valid_i,
    input  logic       ifu_rsp_err_i,
    output logic       inst_latch_en_o,
    input  logic       dec_load_i,
    input  logic       dec_store_i,
    input  logic       dec_bjp_i,
    input  logic       dec_rd_wr_en_i,
    input  logic       dec_ebreak_i,
    input  logic       dec_invalid_i,
    output logic       lsu_req_valid_o,
    input  logic       lsu_req_ready_i,
    input  logic       lsu_rsp_valid_i,
    input  logic       lsu_rsp_err_i,
    output logic       ex_en_o,
    output logic       rf_wr_en_o,
    output logic       pc_upd_en_o,
    output logic       pc_sel_bjp_o,
    output logic       halt_o,
    output logic [1:0] halt_code_o,
    output logic [3:0] state_o
`ifdef YSYX_22040237_PERF_CNT_EN
    ,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_o
`endif
);

    ctrl_state_e state_q, state_d;
    logic [1:0]  halt_code_q, halt_code_d;
    logic        tmr_clear, tmr_expire;

    // The timer restarts on each request acceptance, so IF_WAIT and MEM_WAIT
    // each get a full WAIT_MAX-cycle budget.
    assign tmr_clear = ((state_q == IF_REQ)  && ifu_req_ready_i) ||
                       ((state_q == MEM_REQ) && lsu_req_ready_i);

    ysyx_22040237_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (is_wait_state(state_q)),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET;
            halt_code_q <= HALT_NONE;
        end else begin
            state_q     <= state_d;
            halt_code_q <= halt_code_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        halt_code_d     = halt_code_q;
        ifu_req_valid_o = 1'b0;
        inst_latch_en_o = 1'b0;
        lsu_req_valid_o = 1'b0;
        ex_en_o         = 1'b0;
        rf_wr_en_o      = 1'b0;
        pc_upd_en_o     = 1'b0;
        pc_sel_bjp_o    = 1'b0;
        halt_o          = 1'b0;

        case (state_q)
            RESET: state_d = IF_REQ;

            IF_REQ: begin
                ifu_req_valid_o = 1'b1;
                if (ifu_req_ready_i) state_d = IF_WAIT;
            end

            IF_WAIT: begin
                if (ifu_rsp_valid_i) begin
                    if (ifu_rsp_err_i) begin
                        state_d     = HALT;
                        halt_code_d = HALT_BUSERR;
                    end else begin
                        inst_latch_en_o = 1'b1;
                        state_d         = ID;
                    end
                end else if (tmr_expire) begin
                    state_d     = HALT;
                    halt_code_d = HALT_BUSERR;
                end
            end

            // Invalid outranks ebreak so a malformed encoding that also
            // matches ebreak reports as invalid.
            ID: begin
                if (dec_invalid_i) begin
                    state_d     = HALT;
                    halt_code_d = HALT_INVALID;
                end else if (dec_ebreak_i) begin
                    state_d     = HALT;
                    halt_code_d = HALT_EBREAK;
                end else begin
                    state_d = EX;
                end
            end

            EX: begin
                ex_en_o = 1'b1;
                state_d = (dec_load_i || dec_store_i) ? MEM_REQ : WB;
            end

            MEM_REQ: begin
                lsu_req_valid_o = 1'b1;
                if (lsu_req_ready_i) state_d = MEM_WAIT;
            end

            MEM_WAIT: begin
                if (lsu_rsp_valid_i) begin
                    if (lsu_rsp_err_i) begin
                        state_d     = HALT;
                        halt_code_d = HALT_BUSERR;
                    end else begin
                        state_d = WB;
                    end
                end else if (tmr_expire) begin
                    state_d     = HALT;
                    halt_code_d = HALT_BUSERR;
                end
            end

            WB: begin
                // Stores may carry a stray rd-write flag from the decoder; never commit it.
                rf_wr_en_o   = dec_rd_wr_en_i && !dec_store_i;
                pc_upd_en_o  = 1'b1;
                pc_sel_bjp_o = dec_bjp_i;
                state_d      = IF_REQ;
            end

            HALT: halt_o = 1'b1;

            default: state_d = RESET;
        endcase
    end

    assign halt_code_o = halt_code_q;
    assign state_o     = state_q;

`ifdef YSYX_22040237_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, instret_q;
    logic        retire;

    // ebreak counts as retired even though it never reaches WB.
    assign retire = (state_q == WB) ||
                    ((state_q == ID) && !dec_invalid_i && dec_ebreak_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            if ((state_q != RESET) && (state_q != HALT)) cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (retire) instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instret_o   = instret_q;
`endif

endmodule
